multi_key_filter: RTL and testbench

- Parametrised N-channel successor to the single-key lockout filter.
- Per channel, the block:
  - synchronises the raw input and corrects its polarity;
  - debounces press and release;
  - emits one-cycle press pulses, plus optional auto-repeat pulses while the key is held;
  - exports a clean debounced level.
- Sits between board pushbuttons/switches and control FSMs (processor step/run, register select) that need exactly one event per press.

---
 rtl/multi_key_filter.sv | 147 ++++++++++++++
 tb/tb_multi_key_filter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_key_filter.sv
// N-channel key conditioner: two-flop synchroniser, press/release debounce,
// one-cycle press pulses with optional auto-repeat, and a clean pressed level.
module multi_key_filter #(
   parameter int unsigned N                 = 4,
   parameter bit          ACTIVE_LOW        = 1'b1,
   parameter int unsigned DEBOUNCE_CYC      = 250_000,
   parameter int unsigned REPEAT_DELAY_CYC  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD_CYC = 5_000_000
) (
   input  logic         Clock,
   input  logic         ResetN,
   input  logic         RepeatEn,
   input  logic [N-1:0] In,
   output logic [N-1:0] Out,
   output logic [N-1:0] Level,
   output logic [N-1:0] Strobe
);

   localparam int unsigned MAX_DR  = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ?
                                     DEBOUNCE_CYC : REPEAT_DELAY_CYC;
   localparam int unsigned MAX_CYC = (MAX_DR > REPEAT_PERIOD_CYC) ?
                                     MAX_DR : REPEAT_PERIOD_CYC;
   localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

   localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] RD_LOAD = CW'(REPEAT_DELAY_CYC - 1);
   localparam logic [CW-1:0] RP_LOAD = CW'(REPEAT_PERIOD_CYC - 1);
   localparam logic [N-1:0]  INACTIVE = {N{ACTIVE_LOW}};

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   logic [N-1:0]  sync1;
   logic [N-1:0]  sync2;
   logic [N-1:0]  pressed;

   state_t        state_q [N];
   state_t        state_d [N];
   logic [CW-1:0] cnt_q   [N];
   logic [CW-1:0] cnt_d   [N];
   logic [N-1:0]  out_d;
   logic [N-1:0]  level_d;

   // Synchroniser resets to the idle electrical level so reset never looks like a press
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         sync1 <= INACTIVE;
         sync2 <= INACTIVE;
      end else begin
         sync1 <= In;
         sync2 <= sync1;
      end
   end

   assign pressed = sync2 ^ INACTIVE;

   // State, counter and output registers
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < int'(N); i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         Out   <= '0;
         Level <= '0;
      end else begin
         for (int i = 0; i < int'(N); i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         Out   <= out_d;
         Level <= level_d;
      end
   end

   // Per-channel next-state, counter and pulse decode
   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         out_d[i]   = 1'b0;
         level_d[i] = Level[i];

         case (state_q[i])
            IDLE: begin
               if (pressed[i]) begin
                  cnt_d[i]   = DB_LOAD;
                  state_d[i] = PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (!pressed[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = IDLE;
               end else if (cnt_q[i] == '0) begin
                  out_d[i]   = 1'b1;
                  level_d[i] = 1'b1;
                  cnt_d[i]   = RD_LOAD;
                  state_d[i] = HELD;
               end else begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end
            end
            HELD: begin
               if (!pressed[i]) begin
                  cnt_d[i]   = DB_LOAD;
                  state_d[i] = RELEASE_DB;
               end else if (cnt_q[i] == '0) begin
                  // Expired repeat timer parks at zero until RepeatEn allows a pulse
                  if (RepeatEn) begin
                     out_d[i] = 1'b1;
                     cnt_d[i] = RP_LOAD;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end
            end
            RELEASE_DB: begin
               if (pressed[i]) begin
                  cnt_d[i]   = RP_LOAD;
                  state_d[i] = HELD;
               end else if (cnt_q[i] == '0) begin
                  level_d[i] = 1'b0;
                  state_d[i] = IDLE;
               end else begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         Strobe[i] = (state_q[i] == IDLE);
      end
   end

endmodule

// File: tb/tb_multi_key_filter.sv
// Directed bench for multi_key_filter: press, bounce, repeat, release glitch,
// simultaneous channels and reset during hold.
module tb_multi_key_filter;

   localparam int unsigned N   = 2;
   localparam int unsigned DB  = 4;
   localparam int unsigned RD  = 20;
   localparam int unsigned RP  = 8;

   logic         Clock = 1'b0;
   logic         ResetN;
   logic         RepeatEn;
   logic [N-1:0] In;
   logic [N-1:0] Out;
   logic [N-1:0] Level;
   logic [N-1:0] Strobe;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   multi_key_filter #(
      .N                 (N),
      .ACTIVE_LOW        (1'b1),
      .DEBOUNCE_CYC      (DB),
      .REPEAT_DELAY_CYC  (RD),
      .REPEAT_PERIOD_CYC (RP)
   ) dut (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .RepeatEn (RepeatEn),
      .In       (In),
      .Out      (Out),
      .Level    (Level),
      .Strobe   (Strobe)
   );

   task automatic test_reset();
      ResetN   = 1'b0;
      RepeatEn = 1'b0;
      In       = 2'b11;
      repeat (2) @(negedge Clock);
      checks++;
      if (Out !== 2'b00) begin
         errors++; $display("FAIL reset_out got %b exp 00", Out);
      end
      checks++;
      if (Level !== 2'b00) begin
         errors++; $display("FAIL reset_level got %b exp 00", Level);
      end
      checks++;
      if (Strobe !== 2'b11) begin
         errors++; $display("FAIL reset_strobe got %b exp 11", Strobe);
      end
      ResetN = 1'b1;
      repeat (4) @(negedge Clock);
   endtask

   task automatic test_clean_press();
      logic [1:0] exp_out;
      logic       exp_lvl;
      logic       exp_stb;
      In[0] = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         @(negedge Clock);
         exp_out = (k == 7) ? 2'b01 : 2'b00;
         exp_lvl = (k >= 7) && (k < 17);
         exp_stb = !((k >= 3) && (k < 17));
         checks++;
         if (Out !== exp_out) begin
            errors++; $display("FAIL clean_out k=%0d got %b exp %b", k, Out, exp_out);
         end
         checks++;
         if (Level[0] !== exp_lvl) begin
            errors++; $display("FAIL clean_level k=%0d got %b exp %b", k, Level[0], exp_lvl);
         end
         checks++;
         if (Strobe !== {1'b1, exp_stb}) begin
            errors++; $display("FAIL clean_strobe k=%0d got %b exp %b", k, Strobe, {1'b1, exp_stb});
         end
         if (k == 10) In[0] = 1'b1;
      end
   endtask

   task automatic test_bounce();
      In[0] = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge Clock);
         checks++;
         if (Out !== 2'b00) begin
            errors++; $display("FAIL bounce_out k=%0d got %b exp 00", k, Out);
         end
         checks++;
         if (Level !== 2'b00) begin
            errors++; $display("FAIL bounce_level k=%0d got %b exp 00", k, Level);
         end
         if (k == 3) In[0] = 1'b1;
         if (k == 5) In[0] = 1'b0;
         if (k == 8) In[0] = 1'b1;
      end
      checks++;
      if (Strobe !== 2'b11) begin
         errors++; $display("FAIL bounce_strobe got %b exp 11", Strobe);
      end
   endtask

   task automatic test_auto_repeat(input logic rep, input int exp_pulses);
      int   pulses;
      logic exp_o;
      pulses   = 0;
      RepeatEn = rep;
      In[0]    = 1'b0;
      for (int k = 1; k <= 62; k++) begin
         @(negedge Clock);
         exp_o = rep ? (k inside {7, 27, 35, 43, 51}) : (k == 7);
         checks++;
         if (Out[0] !== exp_o) begin
            errors++; $display("FAIL repeat%0b_out k=%0d got %b exp %b", rep, k, Out[0], exp_o);
         end
         if (Out[0] === 1'b1) pulses++;
         if (k == 50) In[0] = 1'b1;
      end
      checks++;
      if (pulses != exp_pulses) begin
         errors++; $display("FAIL repeat%0b_count got %0d exp %0d", rep, pulses, exp_pulses);
      end
      checks++;
      if (Level !== 2'b00) begin
         errors++; $display("FAIL repeat%0b_level_end got %b exp 00", rep, Level);
      end
      RepeatEn = 1'b0;
   endtask

   task automatic test_release_glitch();
      logic exp_lvl;
      RepeatEn = 1'b0;
      In[0]    = 1'b0;
      for (int k = 1; k <= 42; k++) begin
         @(negedge Clock);
         exp_lvl = (k >= 7) && (k < 36);
         checks++;
         if (Out !== ((k == 7) ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL glitch_out k=%0d got %b exp %b", k, Out, (k == 7) ? 2'b01 : 2'b00);
         end
         checks++;
         if (Level[0] !== exp_lvl) begin
            errors++; $display("FAIL glitch_level k=%0d got %b exp %b", k, Level[0], exp_lvl);
         end
         if (k == 11) In[0] = 1'b1;
         if (k == 13) In[0] = 1'b0;
         if (k == 29) In[0] = 1'b1;
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] exp_lvl;
      In = 2'b00;
      for (int k = 1; k <= 30; k++) begin
         @(negedge Clock);
         exp_lvl = {(k >= 7) && (k < 17), (k >= 7) && (k < 27)};
         checks++;
         if (Out !== ((k == 7) ? 2'b11 : 2'b00)) begin
            errors++; $display("FAIL simul_out k=%0d got %b exp %b", k, Out, (k == 7) ? 2'b11 : 2'b00);
         end
         checks++;
         if (Level !== exp_lvl) begin
            errors++; $display("FAIL simul_level k=%0d got %b exp %b", k, Level, exp_lvl);
         end
         if (k == 10) In[1] = 1'b1;
         if (k == 20) In[0] = 1'b1;
      end
   endtask

   task automatic test_repeat_late();
      logic exp_o;
      RepeatEn = 1'b0;
      In[0]    = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge Clock);
         exp_o = (k inside {7, 31, 39});
         checks++;
         if (Out[0] !== exp_o) begin
            errors++; $display("FAIL late_out k=%0d got %b exp %b", k, Out[0], exp_o);
         end
         if (k == 30) RepeatEn = 1'b1;
         if (k == 40) begin
            In[0]    = 1'b1;
            RepeatEn = 1'b0;
         end
      end
      checks++;
      if (Level !== 2'b00) begin
         errors++; $display("FAIL late_level_end got %b exp 00", Level);
      end
   endtask

   task automatic test_reset_mid_hold();
      In[0] = 1'b0;
      repeat (10) @(negedge Clock);
      checks++;
      if (Level[0] !== 1'b1) begin
         errors++; $display("FAIL midrst_held got %b exp 1", Level[0]);
      end
      ResetN = 1'b0;
      #1;
      checks++;
      if (Level !== 2'b00) begin
         errors++; $display("FAIL midrst_level got %b exp 00", Level);
      end
      checks++;
      if (Strobe !== 2'b11) begin
         errors++; $display("FAIL midrst_strobe got %b exp 11", Strobe);
      end
      checks++;
      if (Out !== 2'b00) begin
         errors++; $display("FAIL midrst_out got %b exp 00", Out);
      end
      @(negedge Clock);
      ResetN = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge Clock);
         checks++;
         if (Out !== ((k == 7) ? 2'b01 : 2'b00)) begin
            errors++; $display("FAIL midrst_out k=%0d got %b exp %b", k, Out, (k == 7) ? 2'b01 : 2'b00);
         end
         checks++;
         if (Level[0] !== ((k >= 7) && (k < 17))) begin
            errors++; $display("FAIL midrst_level k=%0d got %b exp %b", k, Level[0], (k >= 7) && (k < 17));
         end
         if (k == 10) In[0] = 1'b1;
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat(1'b1, 5);
      test_auto_repeat(1'b0, 1);
      test_release_glitch();
      test_simultaneous();
      test_repeat_late();
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
